seg_ring_display: RTL and testbench
===================================

# seg_ring_display

Parametrised N-digit multiplexed seven-segment driver, next generation of the board's four-digit segment controller. Two display modes: a single lit segment chasing around the outer perimeter of the whole digit row (clockwise or counter-clockwise), or an up/down hex counter. The block sits between the board-level top (switch inputs) and the common-anode display pins. It generates its own step and refresh timing from the system clock.

## Interface
- `N_DIGITS`, default 4: number of digits, legal range 2..8.
- `STEP_DIV`, default 50_000_000: clock cycles per animation/count step, legal ≥ 2.
- `REFRESH_DIV`, default 100_000: clock cycles each digit stays selected, legal ≥ 1.
- `clk` in 1: system clock. One clock domain; all logic on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: step enable.
  - 0 freezes the step prescaler, chase position and counter.
  - Display refresh continues while `en`=0.
- `mode` in 1: display mode. 0 = perimeter chase, 1 = hex counter.
- `cw` in 1: chase direction. 1 = clockwise, 0 = counter-clockwise.
- `up` in 1: counter direction. 1 = increment, 0 = decrement.
- `tic` out 1: one-cycle pulse on each step.
- `an` out N_DIGITS: digit enables, active-low. `an[0]` is the rightmost digit.
- `sseg` out 8: segments, active-low. Bit order {dp,g,f,e,d,c,b,a}; `sseg[0]` = a.

## Operation
- **Step prescaler**
  - `step_cnt` counts 0..STEP_DIV-1 while `en`=1, and holds while `en`=0.
  - `tic`=1 in the cycle where `step_cnt`==STEP_DIV-1 and `en`=1. `step_cnt` then returns to 0.
- **Refresh scan**
  - `ref_cnt` counts 0..REFRESH_DIV-1 and runs regardless of `en`.
  - On wrap, `dig` advances 0→1→…→N_DIGITS-1→0.
- **Chase state**
  - `pos` ranges 0..2N+3 (P = 2N+4 positions), ordered clockwise:
    - p in 0..N-1: digit N-1-p, segment a (top run, left to right).
    - p = N: digit 0, segment b. p = N+1: digit 0, segment c.
    - p in N+2..2N+1: digit p-(N+2), segment d (bottom run, right to left).
    - p = 2N+2: digit N-1, segment e. p = 2N+3: digit N-1, segment f.
  - On `tic` with `mode`=0: `pos`+1 if `cw`=1, else `pos`-1, modulo P.
  - Wrap is exact: P-1→0 going clockwise, 0→P-1 going counter-clockwise.
- **Counter state**
  - `value` is 4·N_DIGITS bits wide.
  - On `tic` with `mode`=1: `value`+1 if `up`=1, else -1, modulo 2^(4N).
- Only the active mode's state advances. The inactive state holds its value across mode switches.
- `cw`, `up`, `mode` are sampled only at `tic`. Changes between steps take effect at the next step.
- **Segment decode for the selected digit**
  - Chase: exactly one segment is lit if `pos` maps to `dig`, otherwise 8'hFF.
  - Counter: hex glyph of nibble `value[4·dig +: 4]`. `dp` is always off (1).

## Timing
- Reset values: `step_cnt`=0, `ref_cnt`=0, `dig`=0, `pos`=0, `value`=0, `tic`=0, `an`=all ones, `sseg`=8'hFF.
- `an` and `sseg` are registered with one cycle latency from `dig`/`pos`/`value`.
  - The first cycle after reset release still shows blank.
  - After that, `an` = ~(1<<`dig`).
- `tic` is combinational from `step_cnt` and `en`. State updated by a step is visible on `sseg` two edges after the `tic` cycle.
- The first `tic` occurs STEP_DIV cycles after reset release, with `en` held at 1.
- `en` falling in the `tic` cycle suppresses that step.
- `rst` asserted mid-step or mid-scan returns every register to its reset value immediately. No partial step is retained.
- Simultaneous `tic` and mode change: the step applies to the mode sampled in that cycle.

## Structure
- Package `seg_ring_pkg` holds:
  - segment bit index constants (SEG_A..SEG_DP);
  - the 16-entry active-low hex glyph table, or a `hex_to_seg` function;
  - the `mode_e` enum {MODE_CHASE, MODE_COUNT}.
- Sub-module `seg_tick_gen #(DIV)`: prescaler with `clk`, `rst`, `en` in and a `pulse` out. It is instantiated twice: step prescaler with `en` from the port, refresh prescaler with `en` tied to 1.
- Top `seg_ring_display` holds the position/counter registers, the position-to-(digit, segment) map, and the output registers.

## Test plan
All scenarios use N_DIGITS=4, STEP_DIV=4, REFRESH_DIV=2.
- **Reset:** pulse `rst` mid-run → `an`=4'hF, `sseg`=8'hFF, `tic`=0 during reset. After release, the first `tic` comes exactly 4 cycles later.
- **Chase clockwise:** `mode`=0, `cw`=1, `en`=1 → at `pos`=0, scanning digit 3 (`an`=4'b0111) gives `sseg`=8'hFE and digits 0–2 give 8'hFF. After 5 tics, digit 0 shows 8'hFB (segment c). After 12 tics, `pos` wraps back to 0.
- **Chase counter-clockwise wrap:** from reset, `cw`=0, one tic → `pos`=11, digit 3 shows 8'hDF (segment f).
- **Counter up:** `mode`=1, `up`=1, 3 tics → digit 0 shows 8'hB0 ('3'), digits 1–3 show 8'hC0 ('0').
- **Counter down wrap:** from reset, `up`=0, 1 tic → all four digits show 8'h8E ('F').
- **Enable and mode hold:**
  - `en`=0 for 20 cycles → no `tic`, `pos`/`value` unchanged, `an` still scans.
  - Switch `mode` 0→1→0 → the previous `pos` is restored unchanged.

Source files
------------

// File: rtl/seg_ring_pkg.sv
// Shared definitions for the multiplexed seven-segment ring display:
// segment bit positions, display modes and the active-low hex glyph decoder.
package seg_ring_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic {
    MODE_CHASE = 1'b0,
    MODE_COUNT = 1'b1
  } mode_e;

  // Glyphs are {dp,g,f,e,d,c,b,a}, active-low, with dp always dark.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    logic [7:0] s;
    case (h)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_ring_display_tick.sv
// Clock prescaler: counts enabled cycles 0..DIV-1 and pulses combinationally
// in the last one, so a pulse dropped by en never leaves a partial count.
module seg_tick_gen
  import seg_ring_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pulse
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign pulse = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= pulse ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_ring_display.sv
// N-digit multiplexed seven-segment driver: perimeter chase or hex counter,
// with its own step and refresh prescalers and registered active-low outputs.
module seg_ring_display
  import seg_ring_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int STEP_DIV    = 50_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                cw,
  input  logic                up,
  output logic                tic,
  output logic [N_DIGITS-1:0] an,
  output logic [7:0]          sseg
);

  localparam int P  = 2 * N_DIGITS + 4;
  localparam int PW = $clog2(P);
  localparam int DW = $clog2(N_DIGITS);
  localparam int VW = 4 * N_DIGITS;

  logic          refresh;
  logic [DW-1:0] dig;
  logic [PW-1:0] pos;
  logic [VW-1:0] value;
  mode_e         mode_s;
  int            p_i;
  logic [DW-1:0] chase_dig;
  logic [2:0]    chase_seg;
  logic [7:0]    seg_next;

  assign mode_s = mode_e'(mode);

  seg_tick_gen #(.DIV(STEP_DIV)) u_step (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .pulse (tic)
  );

  seg_tick_gen #(.DIV(REFRESH_DIV)) u_refresh (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .pulse (refresh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig <= '0;
    end else if (refresh) begin
      dig <= (dig == DW'(N_DIGITS - 1)) ? '0 : dig + DW'(1);
    end
  end

  // Only the state of the mode sampled at the step moves; the other one holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos   <= '0;
      value <= '0;
    end else if (tic) begin
      if (mode_s == MODE_CHASE) begin
        if (cw) begin
          pos <= (pos == PW'(P - 1)) ? '0 : pos + PW'(1);
        end else begin
          pos <= (pos == '0) ? PW'(P - 1) : pos - PW'(1);
        end
      end else begin
        value <= up ? value + VW'(1) : value - VW'(1);
      end
    end
  end

  // Clockwise perimeter: top run left to right, right edge, bottom run
  // right to left, then up the left edge.
  always_comb begin
    p_i       = int'(pos);
    chase_dig = '0;
    chase_seg = 3'(SEG_A);
    if (p_i < N_DIGITS) begin
      chase_dig = DW'(N_DIGITS - 1 - p_i);
    end else if (p_i == N_DIGITS) begin
      chase_seg = 3'(SEG_B);
    end else if (p_i == N_DIGITS + 1) begin
      chase_seg = 3'(SEG_C);
    end else if (p_i <= 2 * N_DIGITS + 1) begin
      chase_dig = DW'(p_i - (N_DIGITS + 2));
      chase_seg = 3'(SEG_D);
    end else if (p_i == 2 * N_DIGITS + 2) begin
      chase_dig = DW'(N_DIGITS - 1);
      chase_seg = 3'(SEG_E);
    end else begin
      chase_dig = DW'(N_DIGITS - 1);
      chase_seg = 3'(SEG_F);
    end
  end

  always_comb begin
    seg_next = 8'hFF;
    if (mode_s == MODE_CHASE) begin
      if (chase_dig == dig) begin
        seg_next = ~(8'h01 << chase_seg);
      end
    end else begin
      seg_next = hex_to_seg(value[{dig, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an   <= '1;
      sseg <= 8'hFF;
    end else begin
      an   <= ~(N_DIGITS'(1) << dig);
      sseg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_ring_display.sv
// Bench for seg_ring_display (N=4, STEP_DIV=4, REFRESH_DIV=2): directed
// scenarios then random input changes, all checked against a cycle model.
module tb_seg_ring_display;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int RD = 2;
  localparam int P  = 2 * N + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic       cw;
  logic       up;
  logic       tic;
  logic [3:0] an;
  logic [7:0] sseg;

  int total = 0;
  int bad   = 0;

  int         step_m;
  int         ref_m;
  int         dig_m;
  int         pos_m;
  int         tics_m;
  int         shown_dig;
  logic [15:0] val_m;
  logic [3:0]  exp_an;
  logic [7:0]  exp_sseg;

  int         chase_d[P];
  int         chase_s[P];
  logic [7:0] hex_tab[16];

  always #5 clk = ~clk;

  seg_ring_display #(
    .N_DIGITS    (N),
    .STEP_DIV    (SD),
    .REFRESH_DIV (RD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .cw   (cw),
    .up   (up),
    .tic  (tic),
    .an   (an),
    .sseg (sseg)
  );

  function automatic logic [7:0] model_seg(input int d, input logic m);
    if (!m) return (chase_d[pos_m] == d) ? ~(8'h01 << chase_s[pos_m]) : 8'hFF;
    return hex_tab[(val_m >> (4 * d)) & 16'hF];
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    step_m    = 0;
    ref_m     = 0;
    dig_m     = 0;
    pos_m     = 0;
    val_m     = '0;
    exp_an    = 4'hF;
    exp_sseg  = 8'hFF;
    shown_dig = -1;
  endtask

  // One clock: advance the model at the rising edge, compare at the falling one.
  task automatic runCycle();
    @(posedge clk);
    exp_an    = ~(4'b0001 << dig_m);
    exp_sseg  = model_seg(dig_m, mode);
    shown_dig = dig_m;
    if (en && step_m == SD - 1) begin
      tics_m++;
      step_m = 0;
      if (!mode) pos_m = (pos_m + (cw ? 1 : P - 1)) % P;
      else       val_m = up ? val_m + 16'd1 : val_m - 16'd1;
    end else if (en) begin
      step_m++;
    end
    ref_m++;
    if (ref_m == RD) begin
      ref_m = 0;
      dig_m = (dig_m + 1) % N;
    end
    @(negedge clk);
    checkOutput("an", {12'b0, an}, {12'b0, exp_an});
    checkOutput("sseg", {8'b0, sseg}, {8'b0, exp_sseg});
    checkOutput("tic", {15'b0, tic}, {15'b0, (en && step_m == SD - 1)});
  endtask

  task automatic applyStimulus(input logic e, input logic m, input logic c, input logic u, input int n);
    en   = e;
    mode = m;
    cw   = c;
    up   = u;
    repeat (n) runCycle();
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    #1 resetModel();
    checkOutput("rst_an", {12'b0, an}, 16'h000F);
    checkOutput("rst_sseg", {8'b0, sseg}, 16'h00FF);
    checkOutput("rst_tic", {15'b0, tic}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hold_an", {12'b0, an}, 16'h000F);
    checkOutput("rst_hold_sseg", {8'b0, sseg}, 16'h00FF);
    rst = 1'b0;
  endtask

  task automatic runTics(input int n);
    int target;
    int guard;
    target = tics_m + n;
    guard  = 0;
    en     = 1'b1;
    while (tics_m < target && guard < 200) begin
      runCycle();
      guard++;
    end
  endtask

  task automatic showDigit(input int d, input logic [7:0] expv, input string tag);
    int guard;
    guard = 0;
    runCycle();
    while (shown_dig != d && guard < 16) begin
      runCycle();
      guard++;
    end
    checkOutput(tag, {8'b0, sseg}, {8'b0, expv});
  endtask

  initial begin
    int edges;
    int tc;
    rst    = 1'b1;
    en     = 1'b0;
    mode   = 1'b0;
    cw     = 1'b1;
    up     = 1'b1;
    tics_m = 0;
    hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    for (int p = 0; p < P; p++) begin
      if (p < N)              begin chase_d[p] = N - 1 - p; chase_s[p] = 0; end
      else if (p == N)        begin chase_d[p] = 0;         chase_s[p] = 1; end
      else if (p == N + 1)    begin chase_d[p] = 0;         chase_s[p] = 2; end
      else if (p <= 2*N + 1)  begin chase_d[p] = p - N - 2; chase_s[p] = 3; end
      else if (p == 2*N + 2)  begin chase_d[p] = N - 1;     chase_s[p] = 4; end
      else                    begin chase_d[p] = N - 1;     chase_s[p] = 5; end
    end
    resetModel();
    @(negedge clk);

    // Chase at position 0: only the top segment of the leftmost digit.
    doReset();
    en = 1'b0;
    for (int d = 0; d < N; d++) showDigit(d, (d == N - 1) ? 8'hFE : 8'hFF, "chase_pos0");

    // Mid-run reset, then latency to the first step.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 6);
    doReset();
    edges = 0;
    while (edges < 20) begin
      runCycle();
      edges++;
      if (tic === 1'b1) break;
    end
    checkOutput("first_tic_edges", 16'(edges), 16'(SD - 1));

    runTics(5);
    en = 1'b0;
    showDigit(0, 8'hFB, "chase_cw_pos5");
    runTics(7);
    en = 1'b0;
    showDigit(N - 1, 8'hFE, "chase_cw_wrap");

    mode = 1'b0;
    cw   = 1'b0;
    doReset();
    runTics(1);
    en = 1'b0;
    showDigit(N - 1, 8'hDF, "chase_ccw_wrap");

    mode = 1'b1;
    up   = 1'b1;
    doReset();
    runTics(3);
    en = 1'b0;
    showDigit(0, 8'hB0, "count_up_d0");
    for (int d = 1; d < N; d++) showDigit(d, 8'hC0, "count_up_hi");

    up = 1'b0;
    doReset();
    runTics(1);
    en = 1'b0;
    for (int d = 0; d < N; d++) showDigit(d, 8'h8E, "count_down_wrap");

    // Enable freeze and mode switching with the inactive state held.
    mode = 1'b0;
    cw   = 1'b1;
    doReset();
    runTics(3);
    en = 1'b0;
    showDigit(0, 8'hFE, "chase_pos3");
    tc = 0;
    for (int i = 0; i < 20; i++) begin
      runCycle();
      if (tic === 1'b1) tc++;
    end
    checkOutput("no_tic_en0", 16'(tc), 16'd0);
    showDigit(0, 8'hFE, "pos_hold_en0");
    mode = 1'b1;
    up   = 1'b1;
    runTics(2);
    en = 1'b0;
    showDigit(0, 8'hA4, "count_2");
    mode = 1'b0;
    showDigit(0, 8'hFE, "pos_restored");
    mode = 1'b1;
    showDigit(0, 8'hA4, "value_restored");

    // Random input changes, including en drops in step cycles and resets.
    for (int k = 0; k < 60; k++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 12)));
      if ($urandom_range(0, 15) == 0) doReset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
